// File: rtl/addsub_accumulator_pkg.sv
// Shared opcodes and FSM state encoding for the add/subtract accumulator.
package addsub_accumulator_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

endpackage

// File: rtl/addsub_accumulator_if.sv
// Operand/result handshake bus of the accumulator plus its status readout.
interface addsub_accumulator_if #(
  parameter int N     = 4,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic [1:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     acc;
  logic             c_out;
  logic             overflow;
  logic             ovf_sticky;
  logic [CNT_W-1:0] op_count;

  modport master (
    output in_valid, in_data, in_op, out_ready,
    input  in_ready, out_valid, acc, c_out, overflow, ovf_sticky, op_count
  );

  modport slave (
    input  in_valid, in_data, in_op, out_ready,
    output in_ready, out_valid, acc, c_out, overflow, ovf_sticky, op_count
  );
endinterface

// File: rtl/addsub_accumulator_adder_subtractor.sv
// Combinational N-bit adder/subtractor: s = x + y (add_n=0) or x + ~y + 1 (add_n=1).
module adder_subtractor #(
  parameter int n = 4
) (
  input  logic [n-1:0] x,
  input  logic [n-1:0] y,
  input  logic         add_n,
  output logic [n-1:0] s,
  output logic         c_out,
  output logic         overflow
);
  logic [n-1:0] y_eff;

  assign y_eff = y ^ {n{add_n}};
  assign {c_out, s} = {1'b0, x} + {1'b0, y_eff} + {{n{1'b0}}, add_n};
  // Signed overflow: both addends share a sign that the sum does not.
  assign overflow = (x[n-1] == y_eff[n-1]) && (s[n-1] != x[n-1]);
endmodule

// File: rtl/addsub_accumulator.sv
// Handshaked accumulator around adder_subtractor: IDLE -> EXEC -> RESP per operand.
// Optional clamp-on-overflow of the accumulator when ACC_SATURATE_EN is defined.
module addsub_accumulator
  import addsub_accumulator_pkg::*;
#(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  addsub_accumulator_if.slave  bus
);
  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [N-1:0]     operand_q, operand_d;
  logic [N-1:0]     acc_q, acc_d;
  logic             c_out_q, c_out_d;
  logic             overflow_q, overflow_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [N-1:0]     add_s;
  logic             add_c;
  logic             add_ovf;
  logic [N-1:0]     sum_final;

  adder_subtractor #(.n(N)) u_addsub (
    .x        (acc_q),
    .y        (operand_q),
    .add_n    (op_q == OP_SUB),
    .s        (add_s),
    .c_out    (add_c),
    .overflow (add_ovf)
  );

`ifdef ACC_SATURATE_EN
  localparam logic [N-1:0] ACC_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] ACC_MIN = {1'b1, {(N-1){1'b0}}};
  // On overflow the true result carries the sign shared by both addends, i.e. acc's sign.
  assign sum_final = add_ovf ? (acc_q[N-1] ? ACC_MIN : ACC_MAX) : add_s;
`else
  assign sum_final = add_s;
`endif

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    operand_d     = operand_q;
    acc_d         = acc_q;
    c_out_d       = c_out_q;
    overflow_d    = overflow_q;
    sticky_d      = sticky_q;
    count_d       = count_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;

    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          op_d      = bus.in_op;
          operand_d = bus.in_data;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        case (op_q)
          OP_ADD, OP_SUB: begin
            acc_d      = sum_final;
            c_out_d    = add_c;
            overflow_d = add_ovf;
            sticky_d   = sticky_q | add_ovf;
          end
          OP_LOAD: begin
            acc_d      = operand_q;
            c_out_d    = 1'b0;
            overflow_d = 1'b0;
          end
          OP_CLR: begin
            acc_d      = '0;
            c_out_d    = 1'b0;
            overflow_d = 1'b0;
            sticky_d   = 1'b0;
          end
          default: ;
        endcase
        if (count_q != {CNT_W{1'b1}})
          count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        state_d = RESP;
      end
      RESP: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= OP_ADD;
      operand_q  <= '0;
      acc_q      <= '0;
      c_out_q    <= 1'b0;
      overflow_q <= 1'b0;
      sticky_q   <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      operand_q  <= operand_d;
      acc_q      <= acc_d;
      c_out_q    <= c_out_d;
      overflow_q <= overflow_d;
      sticky_q   <= sticky_d;
      count_q    <= count_d;
    end
  end

  assign bus.acc        = acc_q;
  assign bus.c_out      = c_out_q;
  assign bus.overflow   = overflow_q;
  assign bus.ovf_sticky = sticky_q;
  assign bus.op_count   = count_q;
endmodule

// File: tb/tb_addsub_accumulator.sv
// Directed self-checking bench for addsub_accumulator (N=4, CNT_W=8).
module tb_addsub_accumulator;
  import addsub_accumulator_pkg::*;

  localparam int N     = 4;
  localparam int CNT_W = 8;

`ifdef ACC_SATURATE_EN
  localparam logic [N-1:0] EXP_ADD_OVF = 4'b0111;
  localparam logic [N-1:0] EXP_SUB_OVF = 4'b0111;
  localparam logic [N-1:0] EXP_NEG_OVF = 4'b1000;
`else
  localparam logic [N-1:0] EXP_ADD_OVF = 4'b1011;
  localparam logic [N-1:0] EXP_SUB_OVF = 4'b1001;
  localparam logic [N-1:0] EXP_NEG_OVF = 4'b0111;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  addsub_accumulator_if #(.N(N), .CNT_W(CNT_W)) bus ();

  addsub_accumulator #(.N(N), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Present one operand and advance until the result is in RESP (no ack).
  task automatic run_op(input logic [1:0] op, input logic [N-1:0] d);
    int guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 20) begin
      tests++; fails++;
      $display("FAIL accept_timeout: in_ready=%b required 1", bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_data  = d;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic ack();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tests++;
    if (bus.acc !== 4'b0000 || bus.c_out !== 1'b0 || bus.overflow !== 1'b0 ||
        bus.ovf_sticky !== 1'b0 || bus.op_count !== 8'd0 ||
        bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: acc=%b c=%b ovf=%b sticky=%b cnt=%0d rdy=%b vld=%b required 0000 0 0 0 0 1 0",
               bus.acc, bus.c_out, bus.overflow, bus.ovf_sticky, bus.op_count, bus.in_ready, bus.out_valid);
    end
    $display("[TB] reset: acc=%b cnt=%0d", bus.acc, bus.op_count);
  endtask

  task automatic test_add_overflow();
    run_op(OP_LOAD, 4'd5);
    tests++;
    if (bus.out_valid !== 1'b1 || bus.acc !== 4'b0101) begin
      fails++;
      $display("FAIL load5: vld=%b acc=%b required 1 0101", bus.out_valid, bus.acc);
    end
    ack();
    run_op(OP_ADD, 4'd6);
    tests++;
    if (bus.acc !== EXP_ADD_OVF || bus.c_out !== 1'b0 || bus.overflow !== 1'b1 ||
        bus.ovf_sticky !== 1'b1 || bus.op_count !== 8'd2) begin
      fails++;
      $display("FAIL add_ovf: acc=%b c=%b ovf=%b sticky=%b cnt=%0d required %b 0 1 1 2",
               bus.acc, bus.c_out, bus.overflow, bus.ovf_sticky, bus.op_count, EXP_ADD_OVF);
    end
    $display("[TB] LOAD 5, ADD 6: acc=%b c=%b ovf=%b", bus.acc, bus.c_out, bus.overflow);
    ack();
  endtask

  task automatic test_sub_overflow();
    run_op(OP_CLR, 4'd0);
    tests++;
    if (bus.acc !== 4'b0000 || bus.ovf_sticky !== 1'b0) begin
      fails++;
      $display("FAIL clr1: acc=%b sticky=%b required 0000 0", bus.acc, bus.ovf_sticky);
    end
    ack();
    run_op(OP_LOAD, 4'd6);
    ack();
    run_op(OP_SUB, 4'b1101);
    tests++;
    if (bus.acc !== EXP_SUB_OVF || bus.c_out !== 1'b0 || bus.overflow !== 1'b1 ||
        bus.ovf_sticky !== 1'b1 || bus.op_count !== 8'd5) begin
      fails++;
      $display("FAIL sub_ovf: acc=%b c=%b ovf=%b sticky=%b cnt=%0d required %b 0 1 1 5",
               bus.acc, bus.c_out, bus.overflow, bus.ovf_sticky, bus.op_count, EXP_SUB_OVF);
    end
    $display("[TB] LOAD 6, SUB -3: acc=%b c=%b ovf=%b", bus.acc, bus.c_out, bus.overflow);
    ack();
  endtask

  task automatic test_neg_overflow();
    run_op(OP_CLR, 4'd0);
    ack();
    run_op(OP_LOAD, 4'b1100);
    ack();
    run_op(OP_ADD, 4'b1011);
    tests++;
    if (bus.acc !== EXP_NEG_OVF || bus.c_out !== 1'b1 || bus.overflow !== 1'b1 ||
        bus.ovf_sticky !== 1'b1) begin
      fails++;
      $display("FAIL neg_ovf: acc=%b c=%b ovf=%b sticky=%b required %b 1 1 1",
               bus.acc, bus.c_out, bus.overflow, bus.ovf_sticky, EXP_NEG_OVF);
    end
    $display("[TB] LOAD -4, ADD -5: acc=%b c=%b ovf=%b", bus.acc, bus.c_out, bus.overflow);
    ack();
    run_op(OP_LOAD, 4'd3);
    tests++;
    if (bus.acc !== 4'b0011 || bus.c_out !== 1'b0 || bus.overflow !== 1'b0 || bus.ovf_sticky !== 1'b1) begin
      fails++;
      $display("FAIL load_keeps_sticky: acc=%b c=%b ovf=%b sticky=%b required 0011 0 0 1",
               bus.acc, bus.c_out, bus.overflow, bus.ovf_sticky);
    end
    ack();
    run_op(OP_CLR, 4'd0);
    tests++;
    if (bus.acc !== 4'b0000 || bus.ovf_sticky !== 1'b0 || bus.op_count !== 8'd10) begin
      fails++;
      $display("FAIL clr_sticky: acc=%b sticky=%b cnt=%0d required 0000 0 10",
               bus.acc, bus.ovf_sticky, bus.op_count);
    end
    $display("[TB] LOAD 3, CLR: sticky=%b cnt=%0d", bus.ovf_sticky, bus.op_count);
    ack();
  endtask

  task automatic test_carry_wrap();
    run_op(OP_LOAD, 4'b1111);
    ack();
    run_op(OP_ADD, 4'b0001);
    tests++;
    if (bus.acc !== 4'b0000 || bus.c_out !== 1'b1 || bus.overflow !== 1'b0 || bus.ovf_sticky !== 1'b0) begin
      fails++;
      $display("FAIL wrap_add: acc=%b c=%b ovf=%b sticky=%b required 0000 1 0 0",
               bus.acc, bus.c_out, bus.overflow, bus.ovf_sticky);
    end
    $display("[TB] LOAD -1, ADD 1: acc=%b c=%b", bus.acc, bus.c_out);
    ack();
    run_op(OP_LOAD, 4'd2);
    ack();
    run_op(OP_SUB, 4'd3);
    tests++;
    if (bus.acc !== 4'b1111 || bus.c_out !== 1'b0 || bus.overflow !== 1'b0 || bus.op_count !== 8'd14) begin
      fails++;
      $display("FAIL sub_borrow: acc=%b c=%b ovf=%b cnt=%0d required 1111 0 0 14",
               bus.acc, bus.c_out, bus.overflow, bus.op_count);
    end
    $display("[TB] LOAD 2, SUB 3: acc=%b c=%b", bus.acc, bus.c_out);
    ack();
  endtask

  task automatic test_backpressure();
    int bad = 0;
    run_op(OP_LOAD, 4'd2);
    bus.in_valid = 1'b1;
    bus.in_op    = OP_ADD;
    bus.in_data  = 4'd7;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.acc !== 4'b0010) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL backpressure_hold: %0d bad cycles (vld=%b rdy=%b acc=%b) required 0",
               bad, bus.out_valid, bus.in_ready, bus.acc);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL backpressure_release: vld=%b rdy=%b required 0 1", bus.out_valid, bus.in_ready);
    end
    @(posedge clk); #1;
    tests++;
    if (bus.acc !== 4'b0010 || bus.op_count !== 8'd15 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL backpressure_no_extra: acc=%b cnt=%0d rdy=%b required 0010 15 1",
               bus.acc, bus.op_count, bus.in_ready);
    end
    $display("[TB] backpressure: acc=%b cnt=%0d", bus.acc, bus.op_count);
  endtask

  task automatic test_reset_exec();
    int pulses = 0;
    bus.in_valid = 1'b1;
    bus.in_op    = OP_ADD;
    bus.in_data  = 4'd3;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    tests++;
    if (bus.acc !== 4'b0000 || bus.op_count !== 8'd0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_exec: acc=%b cnt=%0d rdy=%b vld=%b required 0000 0 1 0",
               bus.acc, bus.op_count, bus.in_ready, bus.out_valid);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0) pulses++;
    end
    tests++;
    if (pulses != 0 || bus.acc !== 4'b0000) begin
      fails++;
      $display("FAIL reset_discard: %0d out_valid cycles, acc=%b required 0 0000", pulses, bus.acc);
    end
    $display("[TB] reset during EXEC: acc=%b cnt=%0d", bus.acc, bus.op_count);
  endtask

  task automatic test_count_saturate();
    for (int i = 0; i < 256; i++) begin
      run_op(OP_CLR, 4'd0);
      ack();
    end
    tests++;
    if (bus.op_count !== 8'd255) begin
      fails++;
      $display("FAIL count_saturate: cnt=%0d required 255", bus.op_count);
    end
    $display("[TB] 256 ops: cnt=%0d", bus.op_count);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_op     = OP_ADD;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_add_overflow();
    test_sub_overflow();
    test_neg_overflow();
    test_carry_wrap();
    test_backpressure();
    test_reset_exec();
    test_count_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
